// File: rtl/jpeg_bitrd_pkg.sv
// Shared types and byte constants for the JPEG entropy-coded bit reader.
package jpeg_bitrd_pkg;

    typedef enum logic [1:0] {
        IDLE,
        FF_PEND,
        MARKER
    } bitrd_state_e;

    localparam logic [7:0] BYTE_FF     = 8'hFF;
    localparam logic [7:0] BYTE_STUFF  = 8'h00;
    localparam logic [7:0] MARKER_EOI  = 8'hD9;
    localparam logic [7:0] MARKER_RST0 = 8'hD0;

endpackage

// File: rtl/jpeg_destuffer.sv
// Byte FSM: removes 0xFF 0x00 stuffing, drops 0xFF fill bytes and latches marker codes.
module jpeg_destuffer
    import jpeg_bitrd_pkg::*;
(
    input  logic       clk,
    input  logic       rst,
    input  logic       in_valid,
    input  logic [7:0] in_data,
    output logic       in_ready,
    input  logic       space_ok,
    input  logic       resync,
    output logic       ins_valid,
    output logic [7:0] ins_data,
    output logic       marker_valid,
    output logic [7:0] marker_code
);

    bitrd_state_e state_q, state_d;
    logic [7:0]   code_q, code_d;
    logic         accept;

    // space_ok comes from the registered bit count, so in_ready has no input-port path.
    assign in_ready     = (state_q != MARKER) && space_ok;
    assign accept       = in_valid && in_ready;
    assign marker_valid = (state_q == MARKER);
    assign marker_code  = code_q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
            code_q  <= '0;
        end else begin
            state_q <= state_d;
            code_q  <= code_d;
        end
    end

    always_comb begin
        state_d   = state_q;
        code_d    = code_q;
        ins_valid = 1'b0;
        ins_data  = in_data;
        if (resync) begin
            state_d = IDLE;
            code_d  = '0;
        end else if (accept) begin
            unique case (state_q)
                IDLE: begin
                    if (in_data == BYTE_FF) begin
                        state_d = FF_PEND;
                    end else begin
                        ins_valid = 1'b1;
                    end
                end
                FF_PEND: begin
                    if (in_data == BYTE_STUFF) begin
                        ins_valid = 1'b1;
                        ins_data  = BYTE_FF;
                        state_d   = IDLE;
                    end else if (in_data != BYTE_FF) begin
                        code_d  = in_data;
                        state_d = MARKER;
                    end
                end
                MARKER: begin
                    state_d = MARKER;
                end
                default: begin
                    state_d = IDLE;
                end
            endcase
        end
    end

endmodule

// File: rtl/jpeg_bit_reader.sv
// MSB-aligned bit buffer with a peek window and variable-length consume, fed by the destuffer.
module jpeg_bit_reader
    import jpeg_bitrd_pkg::*;
#(
    parameter int unsigned BUF_W  = 32,
    parameter int unsigned PEEK_W = 16,
    localparam int unsigned CW    = $clog2(BUF_W + 1),
    localparam int unsigned LW    = $clog2(PEEK_W + 1)
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              in_valid,
    input  logic [7:0]        in_data,
    output logic              in_ready,
    output logic [PEEK_W-1:0] peek,
    output logic [CW-1:0]     bit_count,
    input  logic              consume_valid,
    input  logic [LW-1:0]     consume_len,
    output logic              marker_valid,
    output logic [7:0]        marker_code,
    input  logic              resync,
    output logic              underflow
);

    logic [BUF_W-1:0] bits_q, bits_d;
    logic [CW-1:0]    bit_count_q, bit_count_d;
    logic             underflow_q, underflow_d;
    logic             space_ok;
    logic             ins_valid;
    logic [7:0]       ins_data;
    logic             legal;
    logic [CW-1:0]    len;
    logic [CW-1:0]    rem;

    assign space_ok  = (bit_count_q <= CW'(BUF_W - 8));
    assign peek      = bits_q[BUF_W-1 -: PEEK_W];
    assign bit_count = bit_count_q;
    assign underflow = underflow_q;

    jpeg_destuffer u_destuffer (
        .clk          (clk),
        .rst          (rst),
        .in_valid     (in_valid),
        .in_data      (in_data),
        .in_ready     (in_ready),
        .space_ok     (space_ok),
        .resync       (resync),
        .ins_valid    (ins_valid),
        .ins_data     (ins_data),
        .marker_valid (marker_valid),
        .marker_code  (marker_code)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            bits_q      <= '0;
            bit_count_q <= '0;
            underflow_q <= 1'b0;
        end else begin
            bits_q      <= bits_d;
            bit_count_q <= bit_count_d;
            underflow_q <= underflow_d;
        end
    end

    always_comb begin
        legal       = consume_valid && (CW'(consume_len) <= bit_count_q);
        len         = legal ? CW'(consume_len) : '0;
        rem         = bit_count_q - len;
        bits_d      = bits_q << len;
        // New byte lands directly below the bits that survive this cycle's consume.
        if (ins_valid) begin
            bits_d = bits_d | ({ins_data, {(BUF_W - 8){1'b0}}} >> rem);
        end
        bit_count_d = rem + (ins_valid ? CW'(8) : CW'(0));
        underflow_d = underflow_q | (consume_valid & ~legal);
        if (resync) begin
            bits_d      = '0;
            bit_count_d = '0;
            underflow_d = 1'b0;
        end
    end

endmodule

// File: tb/tb_jpeg_bit_reader.sv
// Directed and randomized checks of jpeg_bit_reader against a bit-queue reference model.
module tb_jpeg_bit_reader;
    import jpeg_bitrd_pkg::*;

    localparam int BUF_W  = 32;
    localparam int PEEK_W = 16;

    logic        clk = 1'b0;
    logic        rst;
    logic        in_valid;
    logic [7:0]  in_data;
    logic        in_ready;
    logic [15:0] peek;
    logic [5:0]  bit_count;
    logic        consume_valid;
    logic [4:0]  consume_len;
    logic        marker_valid;
    logic [7:0]  marker_code;
    logic        resync;
    logic        underflow;

    int checks   = 0;
    int failures = 0;

    // Reference model: the stream of valid bits, oldest first.
    bit         mq[$];
    bit         m_pend;
    bit         m_mark;
    bit         m_under;
    logic [7:0] m_code;

    jpeg_bit_reader #(
        .BUF_W  (BUF_W),
        .PEEK_W (PEEK_W)
    ) dut (
        .clk           (clk),
        .rst           (rst),
        .in_valid      (in_valid),
        .in_data       (in_data),
        .in_ready      (in_ready),
        .peek          (peek),
        .bit_count     (bit_count),
        .consume_valid (consume_valid),
        .consume_len   (consume_len),
        .marker_valid  (marker_valid),
        .marker_code   (marker_code),
        .resync        (resync),
        .underflow     (underflow)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    function automatic logic [15:0] m_peek();
        logic [15:0] p = '0;
        for (int i = 0; i < 16; i++) begin
            if (i < mq.size()) p[15-i] = mq[i];
        end
        return p;
    endfunction

    function automatic bit m_ready();
        return !m_mark && (mq.size() <= BUF_W - 8);
    endfunction

    task automatic m_reset();
        mq.delete();
        m_pend  = 1'b0;
        m_mark  = 1'b0;
        m_under = 1'b0;
        m_code  = 8'h00;
    endtask

    task automatic push_byte(input logic [7:0] b);
        for (int i = 7; i >= 0; i--) mq.push_back(b[i]);
    endtask

    task automatic check_all(input string tag);
        chk({tag, ":bit_count"}, 32'(bit_count), 32'(mq.size()));
        chk({tag, ":peek"}, 32'(peek), 32'(m_peek()));
        chk({tag, ":marker_valid"}, 32'(marker_valid), 32'(m_mark));
        chk({tag, ":underflow"}, 32'(underflow), 32'(m_under));
        chk({tag, ":in_ready"}, 32'(in_ready), 32'(m_ready()));
        if (m_mark) chk({tag, ":marker_code"}, 32'(marker_code), 32'(m_code));
    endtask

    // One clock: drive inputs, advance model across the edge, check all outputs.
    task automatic cycle(input bit iv, input logic [7:0] d, input bit cv, input int cl,
                         input bit rs, input string tag);
        bit acc;
        in_valid      = iv;
        in_data       = d;
        consume_valid = cv;
        consume_len   = 5'(cl);
        resync        = rs;
        acc           = iv && m_ready();
        @(posedge clk);
        if (rs) begin
            m_reset();
        end else begin
            if (cv) begin
                if (cl <= mq.size()) repeat (cl) void'(mq.pop_front());
                else m_under = 1'b1;
            end
            if (acc) begin
                if (!m_pend) begin
                    if (d == 8'hFF) m_pend = 1'b1;
                    else push_byte(d);
                end else if (d == 8'h00) begin
                    push_byte(8'hFF);
                    m_pend = 1'b0;
                end else if (d != 8'hFF) begin
                    m_code = d;
                    m_mark = 1'b1;
                    m_pend = 1'b0;
                end
            end
        end
        #1;
        in_valid      = 1'b0;
        consume_valid = 1'b0;
        consume_len   = '0;
        resync        = 1'b0;
        check_all(tag);
    endtask

    task automatic put(input logic [7:0] d, input string tag);
        cycle(1'b1, d, 1'b0, 0, 1'b0, tag);
    endtask

    task automatic eat(input int n, input string tag);
        cycle(1'b0, 8'h00, 1'b1, n, 1'b0, tag);
    endtask

    task automatic do_resync(input string tag);
        cycle(1'b0, 8'h00, 1'b0, 0, 1'b1, tag);
    endtask

    initial begin
        rst           = 1'b1;
        in_valid      = 1'b0;
        in_data       = '0;
        consume_valid = 1'b0;
        consume_len   = '0;
        resync        = 1'b0;
        m_reset();
        repeat (2) @(posedge clk);
        #1;
        chk("reset:in_ready", 32'(in_ready), 32'd1);
        chk("reset:peek", 32'(peek), 32'd0);
        chk("reset:bit_count", 32'(bit_count), 32'd0);
        chk("reset:marker_valid", 32'(marker_valid), 32'd0);
        chk("reset:marker_code", 32'(marker_code), 32'd0);
        chk("reset:underflow", 32'(underflow), 32'd0);
        rst = 1'b0;
        @(posedge clk);
        #1;

        // Plain bytes and partial consumes
        put(8'hA5, "t1_a5");
        put(8'h3C, "t1_3c");
        chk("t1:peek", 32'(peek), 32'hA53C);
        chk("t1:count", 32'(bit_count), 32'd16);
        eat(4, "t1_eat4");
        chk("t1:peek4", 32'(peek), 32'h53C0);
        chk("t1:count4", 32'(bit_count), 32'd12);
        eat(12, "t1_eat12");
        chk("t1:count0", 32'(bit_count), 32'd0);
        chk("t1:peek0", 32'(peek), 32'h0000);

        // Stuffed 0xFF
        put(BYTE_FF, "t2_ff");
        put(BYTE_STUFF, "t2_00");
        put(8'h12, "t2_12");
        chk("t2:peek", 32'(peek), 32'hFF12);
        chk("t2:count", 32'(bit_count), 32'd16);
        chk("t2:marker", 32'(marker_valid), 32'd0);
        do_resync("t2_resync");

        // Fill bytes then EOI marker
        put(BYTE_FF, "t3_ff0");
        put(BYTE_FF, "t3_ff1");
        put(BYTE_FF, "t3_ff2");
        put(MARKER_EOI, "t3_d9");
        chk("t3:marker_valid", 32'(marker_valid), 32'd1);
        chk("t3:marker_code", 32'(marker_code), 32'hD9);
        chk("t3:count", 32'(bit_count), 32'd0);
        chk("t3:in_ready", 32'(in_ready), 32'd0);
        put(8'h77, "t3_blocked");
        do_resync("t3_resync");
        chk("t3:in_ready_after", 32'(in_ready), 32'd1);
        chk("t3:marker_after", 32'(marker_valid), 32'd0);

        // Accept and consume together at the in_ready threshold
        put(8'h11, "t4_11");
        put(8'h22, "t4_22");
        put(8'h33, "t4_33");
        cycle(1'b1, 8'h44, 1'b1, 8, 1'b0, "t4_44c8");
        chk("t4:count24", 32'(bit_count), 32'd24);
        chk("t4:peek24", 32'(peek), 32'h2233);
        cycle(1'b1, 8'h55, 1'b1, 7, 1'b0, "t4_55c7");
        chk("t4:count25", 32'(bit_count), 32'd25);
        chk("t4:peek25", 32'(peek), 32'h19A2);
        chk("t4:ready25", 32'(in_ready), 32'd0);
        do_resync("t4_resync");

        // Underflow is sticky until resync
        put(8'h5A, "t5_5a");
        eat(10, "t5_bad");
        chk("t5:underflow", 32'(underflow), 32'd1);
        chk("t5:count", 32'(bit_count), 32'd8);
        chk("t5:peek", 32'(peek), 32'h5A00);
        eat(4, "t5_good");
        chk("t5:underflow_sticky", 32'(underflow), 32'd1);
        do_resync("t5_resync");
        chk("t5:underflow_clr", 32'(underflow), 32'd0);

        // Asynchronous reset with a pending 0xFF
        put(8'hAB, "t6_ab");
        put(BYTE_FF, "t6_ff");
        #3;
        rst = 1'b1;
        #1;
        m_reset();
        chk("t6:in_ready", 32'(in_ready), 32'd1);
        chk("t6:peek", 32'(peek), 32'd0);
        chk("t6:count", 32'(bit_count), 32'd0);
        chk("t6:marker_valid", 32'(marker_valid), 32'd0);
        chk("t6:marker_code", 32'(marker_code), 32'd0);
        chk("t6:underflow", 32'(underflow), 32'd0);
        @(posedge clk);
        #1;
        rst = 1'b0;
        @(posedge clk);
        #1;
        put(BYTE_STUFF, "t6_00");
        chk("t6:peek00", 32'(peek), 32'h0000);
        chk("t6:count00", 32'(bit_count), 32'd8);

        // Randomized traffic against the model
        do_resync("rnd_start");
        for (int n = 0; n < 4000; n++) begin
            bit         iv;
            bit         cv;
            bit         rs;
            logic [7:0] d;
            int         cl;
            int         r;
            int         lim;
            iv = ($urandom % 10) < 8;
            r  = $urandom % 10;
            d  = (r == 0) ? 8'hFF : (r == 1) ? 8'h00 : 8'($urandom);
            cv = $urandom % 2;
            lim = (mq.size() < 16) ? mq.size() : 16;
            if ($urandom % 10 == 0) cl = $urandom_range(0, 16);
            else cl = $urandom_range(0, lim);
            rs = m_mark ? ($urandom % 4 == 0) : ($urandom % 100 == 0);
            cycle(iv, d, cv, cl, rs, "rnd");
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/jpeg_bit_reader.md
# jpeg_bit_reader

Byte-to-bit front end for the JPEG decode path. It accepts entropy-coded bytes from the UART receive side, strips JPEG byte stuffing (0xFF 0x00 becomes 0xFF), and detects markers. It keeps an MSB-aligned bit buffer and gives a downstream Huffman decoder a 16-bit peek window plus a variable-length consume port (0..16 bits per cycle). It reads back the bitstream that the JPEG encoder and its serialiser write.

## Interface
Parameters:
- BUF_W, 32: bit-buffer width; must be ≥ PEEK_W + 8.
- PEEK_W, 16: peek window width and maximum consume length.

Ports:
- clk  in  1  single system clock; all logic is synchronous to it.
- rst  in  1  asynchronous, active-high reset.
- in_valid  in  1  byte offered.
- in_data  in  8  entropy-coded byte.
- in_ready  out  1  byte accepted when in_valid && in_ready.
- peek  out  PEEK_W  next bits, MSB = oldest; positions at or beyond bit_count read 0.
- bit_count  out  $clog2(BUF_W+1)  number of valid bits in the buffer.
- consume_valid  in  1  request to drop bits.
- consume_len  in  $clog2(PEEK_W+1)  bits to drop, 0..PEEK_W.
- marker_valid  out  1  held high while a marker is pending.
- marker_code  out  8  second byte of the pending marker.
- resync  in  1  one-cycle pulse: clear buffer and marker, return to IDLE.
- underflow  out  1  sticky error flag; cleared only by rst or resync.

## Operation
- Byte FSM states:
  - IDLE: ordinary byte → insert 8 bits. 0xFF → FF_PEND, nothing inserted yet.
  - FF_PEND: next byte 0x00 → insert 0xFF, go to IDLE. Next byte 0xFF → fill byte, stay in FF_PEND, insert nothing. Any other byte → latch marker_code, go to MARKER.
  - MARKER: in_ready=0. No insertion. Consume continues to operate on the remaining bits.
  - resync (any state) → IDLE; buffer cleared; bit_count=0; marker_valid=0; underflow=0.
- in_ready = (state≠MARKER) && (bit_count ≤ BUF_W−8). It depends on registered state only.
- Buffer holds valid bits in buf[BUF_W−1 : BUF_W−bit_count]. The unused low bits are kept at zero.
- Per cycle, let len = consume_len if the consume is legal, else 0. A consume is legal when consume_valid && consume_len ≤ bit_count.
  - Shift: buf' = buf << len.
  - Insert: when a byte is inserted, OR in data << (BUF_W−8−(bit_count−len)).
  - Count: bit_count' = bit_count − len + (insert ? 8 : 0).
- Accept and consume in the same cycle are both honoured. The in_ready check uses the pre-consume bit_count, which keeps the rule conservative and avoids a combinational path from consume to in_ready.
- Illegal consume (consume_len > bit_count): buffer and count are unchanged, and underflow is set.
- consume_len=0 with consume_valid=1 is legal and is a no-op.
- peek = buf[BUF_W−1 : BUF_W−PEEK_W].

## Timing
- Reset values: in_ready=1, peek=0, bit_count=0, marker_valid=0, marker_code=0, underflow=0, state=IDLE.
- An accepted byte is visible in peek and bit_count on the next cycle, giving 1-cycle latency. A 0xFF data byte appears one cycle after its 0x00 partner is accepted.
- A consume takes effect on the next clock edge. peek and bit_count are registered, with no combinational path from the input ports.
- marker_valid rises the cycle after the marker's second byte is accepted.
- resync has priority over a simultaneous accept or consume; both are discarded that cycle.
- rst asserted mid-operation, including in FF_PEND, returns every output to its reset value immediately. A pending 0xFF is lost.
- Sustained throughput: 1 byte per cycle whenever bit_count ≤ BUF_W−8.

## Structure
- Package jpeg_bitrd_pkg holds:
  - the state enum (IDLE, FF_PEND, MARKER);
  - constants BYTE_FF=8'hFF, BYTE_STUFF=8'h00, MARKER_EOI=8'hD9, MARKER_RST0=8'hD0.
- Sub-module jpeg_destuffer is natural. It contains the byte FSM with the valid/ready input and emits an insert strobe plus data, and the marker strobe plus code. The parent owns the buffer, count, and consume logic.

## Test plan
- Bytes 0xA5, 0x3C → bit_count=16, peek=0xA53C. Consume 4 → peek=0x53C0, bit_count=12. Consume 12 → bit_count=0, peek=0x0000.
- Bytes 0xFF, 0x00, 0x12 → bit_count=16, peek=0xFF12; marker_valid stays 0.
- Bytes 0xFF, 0xFF, 0xFF, 0xD9 → marker_valid=1, marker_code=0xD9, bit_count unchanged, in_ready=0. resync → all cleared, in_ready=1.
- bit_count=24 and a byte offered with consume 8 in the same cycle → byte accepted; bit_count=24 next cycle; peek shows correct bit order. bit_count=25 → in_ready=0.
- bit_count=8 and consume_len=10 → underflow=1, buffer unchanged. underflow stays 1 after a later legal consume; resync clears it.
- Bytes 0xAB, 0xFF, then rst asserted → all outputs at reset values. Byte 0x00 after reset → inserted as data: peek=0x0000, bit_count=8.
